// File: rtl/pdp_mem_arbiter_pkg.sv
// rtl/pdp_mem_arbiter_pkg.sv - shared state and requester id definitions for the PDP memory arbiter
package pdp_mem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_t;

  localparam logic [1:0] ARB_IF = 2'd0;
  localparam logic [1:0] ARB_OF = 2'd1;
  localparam logic [1:0] ARB_WB = 2'd2;

  // Fixed-priority pick: writeback beats operand fetch beats instruction fetch.
  function automatic logic [1:0] fixed_pick(input logic of_req, input logic wb_req);
    if (wb_req) begin
      return ARB_WB;
    end else if (of_req) begin
      return ARB_OF;
    end
    return ARB_IF;
  endfunction

endpackage

// File: rtl/pdp_arb_select.sv
// rtl/pdp_arb_select.sv - winner selection with optional fetch starvation guard (macro PDP_ARB_STARVE_EN)
module pdp_arb_select
  import pdp_mem_arbiter_pkg::*;
`ifdef PDP_ARB_STARVE_EN
#(
  parameter int STARVE_MAX = 8
)
`endif
(
`ifdef PDP_ARB_STARVE_EN
  input  logic       clock,
  input  logic       reset_n,
  input  logic       arb_en,
`endif
  input  logic       if_req,
  input  logic       of_req,
  input  logic       wb_req,
  output logic [1:0] win_id
);

`ifdef PDP_ARB_STARVE_EN
  logic [3:0] starve_cnt;
  logic       starved;

  assign starved = (starve_cnt >= 4'(STARVE_MAX));

  // Pick the winner; a starved fetch overrides the fixed order.
  always_comb begin
    win_id = fixed_pick(of_req, wb_req);
    if (if_req && starved) begin
      win_id = ARB_IF;
    end
  end

  // Count arbitrations that fetch asked for and lost; clear when it wins.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      starve_cnt <= 4'd0;
    end else if (arb_en && if_req) begin
      if (win_id == ARB_IF) begin
        starve_cnt <= 4'd0;
      end else if (starve_cnt != 4'hF) begin
        starve_cnt <= starve_cnt + 4'd1;
      end
    end
  end
`else
  // Pure fixed priority, no history.
  always_comb begin
    win_id = fixed_pick(of_req, wb_req);
  end
`endif

endmodule

// File: rtl/pdp_mem_arbiter.sv
// rtl/pdp_mem_arbiter.sv - single-outstanding memory arbiter for IF/OF/WB (optional macro PDP_ARB_STARVE_EN)
module pdp_mem_arbiter
  import pdp_mem_arbiter_pkg::*;
#(
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 8
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        if_req,
  input  logic [15:0] if_addr,
  input  logic        of_req,
  input  logic [15:0] of_addr,
  input  logic        wb_req,
  input  logic [15:0] wb_addr,
  input  logic [15:0] wb_wdata,
  output logic        if_gnt,
  output logic        of_gnt,
  output logic        wb_gnt,
  output logic        mem_en,
  output logic        mem_we,
  output logic [14:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  output logic        rsp_valid,
  output logic [1:0]  rsp_id,
  output logic [15:0] rsp_data,
  output logic        rsp_err,
  output logic        busy
);

  generate
    if (MEM_LAT < 1 || MEM_LAT > 7 || STARVE_MAX < 1 || STARVE_MAX > 15) begin : g_bad_param
      $error("pdp_mem_arbiter: MEM_LAT or STARVE_MAX out of range");
    end
  endgenerate

  arb_state_t  state, state_nx;
  logic [1:0]  id_q;
  logic [15:0] addr_q;
  logic [15:0] wdata_q;
  logic [15:0] rdata_q;
  logic [2:0]  wait_cnt;
  logic [1:0]  win_id;
  logic        any_req;
  logic        arb_take;
  logic        is_write;
  logic        is_odd;
  logic        wait_last;
  logic        mem_go;

  assign any_req   = if_req | of_req | wb_req;
  assign arb_take  = (state == IDLE) && any_req;
  assign is_write  = (id_q == ARB_WB);
  assign is_odd    = addr_q[0];
  assign wait_last = (wait_cnt == 3'(MEM_LAT - 2));

  pdp_arb_select
`ifdef PDP_ARB_STARVE_EN
  #(
    .STARVE_MAX (STARVE_MAX)
  )
`endif
  u_select (
`ifdef PDP_ARB_STARVE_EN
    .clock   (clock),
    .reset_n (reset_n),
    .arb_en  (arb_take),
`endif
    .if_req  (if_req),
    .of_req  (of_req),
    .wb_req  (wb_req),
    .win_id  (win_id)
  );

  // State register; reset abandons any in-flight access.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next state: odd addresses and writes skip the wait, a 1-cycle memory skips it too.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (any_req) begin
          state_nx = ISSUE;
        end
      end
      ISSUE: begin
        if (is_odd || is_write || (MEM_LAT == 1)) begin
          state_nx = RESP;
        end else begin
          state_nx = WAIT;
        end
      end
      WAIT: begin
        if (wait_last) begin
          state_nx = RESP;
        end
      end
      RESP: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // Latch the winning request, run the wait counter and capture read data.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      id_q     <= 2'd0;
      addr_q   <= 16'd0;
      wdata_q  <= 16'd0;
      rdata_q  <= 16'd0;
      wait_cnt <= 3'd0;
    end else begin
      case (state)
        IDLE: begin
          if (arb_take) begin
            id_q <= win_id;
            case (win_id)
              ARB_WB:  addr_q <= wb_addr;
              ARB_OF:  addr_q <= of_addr;
              default: addr_q <= if_addr;
            endcase
            wdata_q <= (win_id == ARB_WB) ? wb_wdata : 16'd0;
          end
        end
        ISSUE: begin
          wait_cnt <= 3'd0;
          rdata_q  <= 16'd0;
          if ((MEM_LAT == 1) && !is_odd && !is_write) begin
            rdata_q <= mem_rdata;
          end
        end
        WAIT: begin
          if (wait_last) begin
            rdata_q <= mem_rdata;
          end else begin
            wait_cnt <= wait_cnt + 3'd1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Outputs are pure decodes of state so they drop to zero the instant reset asserts.
  always_comb begin
    mem_go    = (state == ISSUE) && !is_odd;
    if_gnt    = (state == ISSUE) && (id_q == ARB_IF);
    of_gnt    = (state == ISSUE) && (id_q == ARB_OF);
    wb_gnt    = (state == ISSUE) && (id_q == ARB_WB);
    mem_en    = mem_go;
    mem_we    = mem_go && is_write;
    mem_addr  = mem_go ? addr_q[15:1] : 15'd0;
    mem_wdata = (mem_go && is_write) ? wdata_q : 16'd0;
    rsp_valid = (state == RESP);
    rsp_id    = (state == RESP) ? id_q : 2'd0;
    rsp_data  = (state == RESP) ? rdata_q : 16'd0;
    rsp_err   = (state == RESP) && is_odd;
    busy      = (state != IDLE);
  end

endmodule
